// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light controller: a prescaled tick counter
// that restarts on ST and raises the short-emergency/short/long expiry flags.
module traffic_timer #(
  parameter int unsigned PRESCALE  = 50_000_000,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TSE_TICKS = 2,
  parameter int unsigned TS_TICKS  = 5,
  parameter int unsigned TL_TICKS  = 15
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             ST,
  input  logic             hold,
  output logic             TSE,
  output logic             TS,
  output logic             TL,
  output logic             tick,
  output logic [CNT_W-1:0] elapsed
);

  localparam int unsigned      PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TSE_TH  = CNT_W'(TSE_TICKS);
  localparam logic [CNT_W-1:0] TS_TH   = CNT_W'(TS_TICKS);
  localparam logic [CNT_W-1:0] TL_TH   = CNT_W'(TL_TICKS);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             tick_q, tick_d;

  // With PRESCALE=1 PRE_MAX is 0, so every non-ST, non-hold edge wraps.
  always_comb begin
    pre_d     = pre_q;
    elapsed_d = elapsed_q;
    tick_d    = 1'b0;
    if (ST) begin
      pre_d     = '0;
      elapsed_d = '0;
    end else if (hold) begin
      pre_d     = pre_q;
    end else if (pre_q == PRE_MAX) begin
      pre_d  = '0;
      tick_d = 1'b1;
      if (elapsed_q != CNT_MAX) begin
        elapsed_d = elapsed_q + 1'b1;
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      pre_q     <= '0;
      elapsed_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      elapsed_q <= elapsed_d;
      tick_q    <= tick_d;
    end
  end

  assign elapsed = elapsed_q;
  assign tick    = tick_q;
  assign TSE     = (elapsed_q >= TSE_TH);
  assign TS      = (elapsed_q >= TS_TH);
  assign TL      = (elapsed_q >= TL_TH);

endmodule

// File: tb/tb_traffic_timer.sv
// Directed-vector bench for traffic_timer: a PRESCALE=4 instance driven from a
// vector table, plus a hand-written PRESCALE=1 sequence.
module tb_traffic_timer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst_a, st_a, hold_a, tse_a, ts_a, tl_a, tick_a;
  logic [3:0] el_a;
  logic       rst_b, st_b, hold_b, tse_b, ts_b, tl_b, tick_b;
  logic [3:0] el_b;

  traffic_timer #(.PRESCALE(4), .CNT_W(4), .TSE_TICKS(2), .TS_TICKS(3), .TL_TICKS(6)) dut_a (
    .Clk(Clk), .reset(rst_a), .ST(st_a), .hold(hold_a),
    .TSE(tse_a), .TS(ts_a), .TL(tl_a), .tick(tick_a), .elapsed(el_a)
  );

  traffic_timer #(.PRESCALE(1), .CNT_W(4), .TSE_TICKS(2), .TS_TICKS(3), .TL_TICKS(6)) dut_b (
    .Clk(Clk), .reset(rst_b), .ST(st_b), .hold(hold_b),
    .TSE(tse_b), .TS(ts_b), .TL(tl_b), .tick(tick_b), .elapsed(el_b)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       hold;
    logic [3:0] el;
    logic       tk;
    string      nm;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic r, logic s, logic h, int el, logic tk, string nm);
    vq.push_back('{r, s, h, 4'(el), tk, nm});
  endfunction

  // Free-running edges j0+1..j0+n after a restart at relative edge 0.
  function automatic void run(int j0, int n, string nm);
    for (int j = j0 + 1; j <= j0 + n; j++) begin
      add(1'b0, 1'b0, 1'b0, (j / 4 > 15) ? 15 : j / 4, (j % 4) == 0, nm);
    end
  endfunction

  function automatic logic [2:0] flags(logic [3:0] el);
    return {el >= 4'd2, el >= 4'd3, el >= 4'd6};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; st_a = 1'b0; hold_a = 1'b0;
    rst_b = 1'b1; st_b = 1'b0; hold_b = 1'b0;

    // Reset, coincident ST, then the long run from ST at edge 0.
    add(1, 0, 0, 0, 0, "reset");
    add(1, 1, 0, 0, 0, "reset_st");
    add(0, 1, 0, 0, 0, "start");
    run(0, 24, "count");
    // Restart, then a second ST at relative edge 14.
    add(0, 1, 0, 0, 0, "restart");
    run(0, 13, "count2");
    add(0, 1, 0, 0, 0, "st_e14");
    run(0, 8, "after_st");
    // ST held high, then saturation over 20 ticks.
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, "st_held");
    run(0, 80, "sat");
    // hold for 5 cycles from edge 2: first tick moves to edge 9.
    add(0, 1, 0, 0, 0, "hstart");
    run(0, 1, "pre_hold");
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, "hold");
    add(0, 0, 0, 0, 0, "resume");
    add(0, 0, 0, 0, 0, "resume");
    add(0, 0, 0, 1, 1, "late_tick");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, "post_tick");
    add(0, 0, 0, 2, 1, "tick2");
    // ST exactly on a prescaler wrap.
    add(0, 1, 0, 0, 0, "wstart");
    run(0, 3, "pre_wrap");
    add(0, 1, 0, 0, 0, "st_wrap");
    run(0, 4, "post_wrap");
    // ST during hold still restarts.
    add(0, 1, 0, 0, 0, "sh_start");
    run(0, 8, "sh_count");
    add(0, 1, 1, 0, 0, "st_hold");
    add(0, 0, 1, 0, 0, "hold_after");
    run(0, 4, "sh_resume");
    // reset mid-count with elapsed=2.
    add(0, 1, 0, 0, 0, "r_start");
    run(0, 9, "r_count");
    add(1, 0, 0, 0, 0, "reset_mid");
    run(0, 4, "after_reset");

    for (int i = 0; i < vq.size(); i++) begin
      rst_a  = vq[i].rst;
      st_a   = vq[i].st;
      hold_a = vq[i].hold;
      step();
      chk({vq[i].nm, "_elapsed"}, i, 32'(el_a), 32'(vq[i].el));
      chk({vq[i].nm, "_tick"}, i, 32'(tick_a), 32'(vq[i].tk));
      chk({vq[i].nm, "_flags"}, i, 32'({tse_a, ts_a, tl_a}), 32'(flags(vq[i].el)));
    end
    rst_a = 1'b1;

    // PRESCALE=1: increments on every non-ST, non-hold edge.
    rst_b = 1'b1;
    step();
    chk("p1_reset", 0, 32'({el_b, tick_b, tse_b, ts_b, tl_b}), 32'd0);
    rst_b = 1'b0; st_b = 1'b1;
    step();
    chk("p1_start", 0, 32'({el_b, tick_b}), 32'd0);
    st_b = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("p1_elapsed", i, 32'(el_b), (i > 15) ? 32'd15 : 32'(i));
      chk("p1_tick", i, 32'(tick_b), 32'd1);
      chk("p1_flags", i, 32'({tse_b, ts_b, tl_b}), 32'(flags((i > 15) ? 4'd15 : 4'(i))));
    end
    hold_b = 1'b1;
    step();
    chk("p1_hold", 0, 32'({el_b, tick_b}), 32'({4'd15, 1'b0}));
    hold_b = 1'b0; st_b = 1'b1;
    step();
    chk("p1_restart", 0, 32'({el_b, tick_b, tse_b, ts_b, tl_b}), 32'd0);
    st_b = 1'b0;
    step();
    chk("p1_first", 0, 32'({el_b, tick_b, tse_b, ts_b, tl_b}), 32'({4'd1, 1'b1, 3'b000}));
    step();
    chk("p1_second", 0, 32'({el_b, tick_b, tse_b, ts_b, tl_b}), 32'({4'd2, 1'b1, 3'b100}));
    rst_b = 1'b1;
    step();
    chk("p1_reset_mid", 0, 32'({el_b, tick_b, tse_b, ts_b, tl_b}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
